// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: destination-register delay line (EX, MEM, WB) compared
// against the decode-stage source registers. It produces the decode stall and
// bubble injection, plus the per-operand forwarding selects for the ALU muxes.
//
// Build option HAZARD_FWD_EN:
//   defined   - full forwarding; only a load-use hazard stalls (one cycle).
//   undefined - no forwarding (selects tied to 00); decode stalls while any
//               slot holds a producer of an active source operand.
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_use,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_use,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_count
);

  // One producer entry of the delay line. The load flag only matters while
  // the producer sits in EX, so it is kept beside the EX slot alone.
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
  } dst_t;

  // Operand select encoding seen by the ALU operand muxes.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_WB    = 2'b11
  } fwd_sel_e;

  dst_t             ex_q,  ex_d;
  dst_t             mem_q, mem_d;
  dst_t             wb_q,  wb_d;
  logic             ex_ld_q, ex_ld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dst_t             dec_dst;

  // Per-slot, per-operand match terms. A slot is only valid when it writes a
  // non-zero rd, so x0 can never produce a hazard.
  logic m_ex_a, m_mem_a, m_wb_a;
  logic m_ex_b, m_mem_b, m_wb_b;

  assign m_ex_a  = ex_q.v  & (ex_q.rd  == id_rs1) & id_rs1_use & id_valid;
  assign m_mem_a = mem_q.v & (mem_q.rd == id_rs1) & id_rs1_use & id_valid;
  assign m_wb_a  = wb_q.v  & (wb_q.rd  == id_rs1) & id_rs1_use & id_valid;
  assign m_ex_b  = ex_q.v  & (ex_q.rd  == id_rs2) & id_rs2_use & id_valid;
  assign m_mem_b = mem_q.v & (mem_q.rd == id_rs2) & id_rs2_use & id_valid;
  assign m_wb_b  = wb_q.v  & (wb_q.rd  == id_rs2) & id_rs2_use & id_valid;

`ifdef HAZARD_FWD_EN
  // Youngest producer wins; a load in EX cannot forward yet, so it falls
  // through to the older slots (the stall covers that cycle anyway).
  function automatic fwd_sel_e pick_fwd(input logic ex_hit, input logic mem_hit,
                                        input logic wb_hit);
    if (ex_hit)       return FWD_EXMEM;
    else if (mem_hit) return FWD_MEMWB;
    else if (wb_hit)  return FWD_WB;
    else              return FWD_RF;
  endfunction
`else
  // Without forwarding the load flag has no consumer.
  logic unused_ex_ld;
  assign unused_ex_ld = ex_ld_q;
`endif

  // Stall and forwarding selects, zero-cycle from slots and decode inputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    stall = 1'b0;
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
`ifdef HAZARD_FWD_EN
    stall = ex_ld_q & (m_ex_a | m_ex_b);
    fwd_a = pick_fwd(m_ex_a & ~ex_ld_q, m_mem_a, m_wb_a);
    fwd_b = pick_fwd(m_ex_b & ~ex_ld_q, m_mem_b, m_wb_b);
`else
    stall = m_ex_a | m_mem_a | m_wb_a | m_ex_b | m_mem_b | m_wb_b;
`endif
  end

  // Destination entry the decode instruction would place into EX.
  always_comb begin
    dec_dst.v  = id_valid & id_rd_we & (id_rd != '0);
    dec_dst.rd = id_rd;
  end

  // Slot shift with bubble injection; flush outranks stall and also kills
  // the instruction entering MEM, while WB still retires the old MEM entry.
  always_comb begin
    wb_d    = mem_q;
    mem_d   = ex_q;
    ex_d    = dec_dst;
    ex_ld_d = id_is_load & dec_dst.v;
    if (flush) begin
      mem_d   = '0;
      ex_d    = '0;
      ex_ld_d = 1'b0;
    end else if (stall) begin
      ex_d    = '0;
      ex_ld_d = 1'b0;
    end
  end

  // Saturating count of stall cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset clears every slot and the counter immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= '0;
      ex_ld_q <= 1'b0;
      mem_q   <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every slot samples the value
      // its neighbour held before this edge, which is what makes it shift.
      ex_q    <= ex_d;
      ex_ld_q <= ex_ld_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_valid    = wb_q.v;
  assign wb_rd       = wb_q.rd;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Expected values are hand-derived for
// both builds (HAZARD_FWD_EN defined or not). A second instance with a 4-bit
// counter shares all inputs so counter saturation is reached in few cycles.
module tb_hazard_scoreboard;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic        id_rs1_use;
  logic [4:0]  id_rs2;
  logic        id_rs2_use;
  logic [4:0]  id_rd;
  logic        id_rd_we;
  logic        id_is_load;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [15:0] stall_count;
  logic        stall_s;
  logic [1:0]  fwd_a_s;
  logic [1:0]  fwd_b_s;
  logic        wb_valid_s;
  logic [4:0]  wb_rd_s;
  logic [3:0]  stall_count_s;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.REG_AW(5), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_use(id_rs1_use),
    .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_count(stall_count)
  );

  hazard_scoreboard #(.REG_AW(5), .CNT_W(4)) u_dut_s (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_use(id_rs1_use),
    .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .flush(flush), .stall(stall_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s),
    .wb_valid(wb_valid_s), .wb_rd(wb_rd_s), .stall_count(stall_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stall and both selects on both instances.
  task automatic chk_hz(input string tag, input logic s, input logic [1:0] fa,
                        input logic [1:0] fb);
    check({tag, "_stall"},   32'(stall),   32'(s));
    check({tag, "_fwd_a"},   32'(fwd_a),   32'(fa));
    check({tag, "_fwd_b"},   32'(fwd_b),   32'(fb));
    check({tag, "_stall_s"}, 32'(stall_s), 32'(s));
    check({tag, "_fwd_a_s"}, 32'(fwd_a_s), 32'(fa));
    check({tag, "_fwd_b_s"}, 32'(fwd_b_s), 32'(fb));
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld);
    id_valid   = v;
    id_rs1     = rs1;
    id_rs1_use = u1;
    id_rs2     = rs2;
    id_rs2_use = u2;
    id_rd      = rd;
    id_rd_we   = we;
    id_is_load = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    idle();
    #3;
    chk_hz("rst", 1'b0, 2'd0, 2'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_cnt", 32'(stall_count), 32'd0);
    #10;
    reset = 1'b0;

    // Load-use: lw x7 ; add x8,x7,x1
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    #1 check("lu_c0_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
    #1 chk_hz("lu_c1", 1'b1, 2'd0, 2'd0);
    check("lu_c1_cnt", 32'(stall_count), 32'd0);
    tick();
    chk_hz("lu_c2", FWD ? 1'b0 : 1'b1, FWD ? 2'd2 : 2'd0, 2'd0);
    check("lu_c2_cnt", 32'(stall_count), 32'd1);
    tick();
    chk_hz("lu_c3", FWD ? 1'b0 : 1'b1, FWD ? 2'd3 : 2'd0, 2'd0);
    check("lu_c3_wb_valid", 32'(wb_valid), 32'd1);
    check("lu_c3_wb_rd", 32'(wb_rd), 32'd7);
    tick();
    chk_hz("lu_c4", 1'b0, 2'd0, 2'd0);
    check("lu_c4_cnt", 32'(stall_count), FWD ? 32'd1 : 32'd3);
    tick();
    idle();
    tick(); tick(); tick();

    // ALU chain: addi x3 ; add x4,x3,x3 held in decode
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    #1 check("alu_c0_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    #1 chk_hz("alu_c1", FWD ? 1'b0 : 1'b1, FWD ? 2'd1 : 2'd0, FWD ? 2'd1 : 2'd0);
    check("alu_c1_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    chk_hz("alu_c2", FWD ? 1'b0 : 1'b1, FWD ? 2'd2 : 2'd0, FWD ? 2'd2 : 2'd0);
    tick();
    chk_hz("alu_c3", FWD ? 1'b0 : 1'b1, FWD ? 2'd3 : 2'd0, FWD ? 2'd3 : 2'd0);
    check("alu_c3_wb_valid", 32'(wb_valid), 32'd1);
    check("alu_c3_wb_rd", 32'(wb_rd), 32'd3);
    tick();
    chk_hz("alu_c4", 1'b0, 2'd0, 2'd0);
    check("alu_c4_cnt", 32'(stall_count), FWD ? 32'd1 : 32'd6);
    tick();
    idle();
    tick(); tick(); tick();

    // x0 writer: addi x0 ; reader of x0 on both operands
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    #1 check("x0_c0_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk_hz($sformatf("x0_c%0d", i + 1), 1'b0, 2'd0, 2'd0);
      tick();
    end
    idle();
    tick(); tick(); tick();

    // Flush: addi x9 ; lw x9 ; reader of x9 with flush in the same cycle
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    #1 check("fl_c0_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    #1 check("fl_c1_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    flush = 1'b1;
    #1 chk_hz("fl_c2", 1'b1, FWD ? 2'd2 : 2'd0, 2'd0);
    check("fl_c2_cnt", 32'(stall_count), FWD ? 32'd1 : 32'd6);
    tick();
    flush = 1'b0;
    #1 chk_hz("fl_c3", FWD ? 1'b0 : 1'b1, FWD ? 2'd3 : 2'd0, 2'd0);
    check("fl_c3_wb_valid", 32'(wb_valid), 32'd1);
    check("fl_c3_wb_rd", 32'(wb_rd), 32'd9);
    check("fl_c3_cnt", 32'(stall_count), FWD ? 32'd2 : 32'd7);
    tick();
    chk_hz("fl_c4", 1'b0, 2'd0, 2'd0);
    check("fl_c4_cnt", 32'(stall_count), FWD ? 32'd2 : 32'd8);
    check("fl_c4_cnt_s", 32'(stall_count_s), FWD ? 32'd2 : 32'd8);
    tick();
    idle();
    tick(); tick(); tick();

    // Saturation: 20 single-cycle load-use stalls push the 4-bit counter past 15
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      tick();
      drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      idle();
      tick();
    end
    check("sat_cnt", 32'(stall_count), FWD ? 32'd22 : 32'd28);
    check("sat_cnt_s", 32'(stall_count_s), 32'd15);

    // Reset mid-stream: x10, x6 older producers, lw x5 in EX, dependent decode
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd11, 1'b1, 1'b0);
    #1 chk_hz("rm_pre", 1'b1, 2'd0, FWD ? 2'd2 : 2'd0);
    check("rm_pre_wb_valid", 32'(wb_valid), 32'd1);
    check("rm_pre_wb_rd", 32'(wb_rd), 32'd10);
    #1 reset = 1'b1;
    #1 chk_hz("rm_async", 1'b0, 2'd0, 2'd0);
    check("rm_async_wb_valid", 32'(wb_valid), 32'd0);
    check("rm_async_wb_rd", 32'(wb_rd), 32'd0);
    check("rm_async_cnt", 32'(stall_count), 32'd0);
    check("rm_async_cnt_s", 32'(stall_count_s), 32'd0);
    check("rm_async_wb_valid_s", 32'(wb_valid_s), 32'd0);
    check("rm_async_wb_rd_s", 32'(wb_rd_s), 32'd0);
    tick();
    reset = 1'b0;
    idle();
    tick();
    check("rm_post_cnt", 32'(stall_count), 32'd0);
    check("rm_post_wb_valid", 32'(wb_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
